// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with a 2-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter for performance debug.
module pipe_stage_reg #(
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    logic              accept;
    logic              drain;
    logic              stall;
    logic              main_valid_nxt;
    logic [DATA_W-1:0] main_data_nxt;
    logic              skid_valid_nxt;
    logic [DATA_W-1:0] skid_data_nxt;

    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign stall     = out_valid & ~out_ready;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

    always_comb begin
        main_valid_nxt = out_valid;
        main_data_nxt  = out_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (flush) begin
            main_valid_nxt = 1'b0;
            main_data_nxt  = BUBBLE_DATA;
            skid_valid_nxt = 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                // in_ready is low while skid is full, so no accept competes here
                main_valid_nxt = 1'b1;
                main_data_nxt  = skid_data;
                skid_valid_nxt = 1'b0;
            end else begin
                main_valid_nxt = accept;
                if (accept) begin
                    main_data_nxt = in_data;
                end
            end
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
            skid_data_nxt  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data     <= BUBBLE_DATA;
            skid_valid   <= 1'b0;
            skid_data    <= BUBBLE_DATA;
            in_ready     <= 1'b1;
            stall_cycles <= '0;
        end else begin
            out_valid  <= main_valid_nxt;
            out_data   <= main_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            // registered copy of !skid_valid keeps in_ready free of comb paths
            in_ready   <= ~skid_valid_nxt;
            if (stall && stall_cycles != CNT_MAX) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
        end
    end

endmodule
